// File: rtl/mem_server_nport_pkg.sv
// Shared message types, op encodings and byte-lane helpers for the
// multi-port memory server.
package mem_server_nport_pkg;

   localparam int c_opaq_bits = 8;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } mem_op_e;

   typedef struct packed {
      mem_op_e                op;
      logic [c_opaq_bits-1:0] opaque;
      logic [31:0]            addr;
      logic [1:0]             len;
      logic [31:0]            data;
   } mem_req_t;

   typedef struct packed {
      mem_op_e                op;
      logic [c_opaq_bits-1:0] opaque;
      logic [31:0]            addr;
      logic [1:0]             len;
      logic [31:0]            data;
   } mem_resp_t;

   // Byte lanes touched by an access; lanes past byte 3 fall off the top.
   function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [1:0] len);
      logic [3:0] nib;
      case (len)
         2'd1:    nib = 4'b0001;
         2'd2:    nib = 4'b0011;
         2'd3:    nib = 4'b0111;
         default: nib = 4'b1111;
      endcase
      return nib << off;
   endfunction

   function automatic logic [31:0] len_mask(input logic [1:0] len);
      case (len)
         2'd1:    return 32'h0000_00ff;
         2'd2:    return 32'h0000_ffff;
         2'd3:    return 32'h00ff_ffff;
         default: return 32'hffff_ffff;
      endcase
   endfunction

endpackage

// File: rtl/mem_server_resp_queue.sv
// Per-port response FIFO; each entry ages after insertion and the head is
// only presented once it has aged p_delay cycles.
module mem_server_resp_queue
   import mem_server_nport_pkg::*;
#(
   parameter int p_depth = 4,
   parameter int p_delay = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  mem_resp_t push_msg,
   output logic      full,
   input  logic      pop_rdy,
   output logic      head_val,
   output mem_resp_t head_msg
);

   localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int c_age_bits = (p_delay > 0) ? $clog2(p_delay + 1) : 1;
   localparam logic [c_age_bits-1:0] c_age_max = c_age_bits'(p_delay);
   localparam logic [c_ptr_bits:0]   c_full    = (c_ptr_bits + 1)'(p_depth);

   mem_resp_t             entries [p_depth];
   logic [c_age_bits-1:0] age     [p_depth];
   logic [c_ptr_bits-1:0] wr_ptr, rd_ptr;
   logic [c_ptr_bits:0]   count;
   logic                  pop, do_push;

   assign full     = (count == c_full);
   assign head_val = !rst && (count != '0) && (age[rd_ptr] == c_age_max);
   assign head_msg = rst ? '0 : entries[rd_ptr];
   assign pop      = head_val && pop_rdy;
   assign do_push  = push && (!full || pop);

   // NOTE: payload storage has no reset; validity is tracked by count alone,
   // so clearing it would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_msg;
   end

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < p_depth; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < p_depth; i++) begin
            if (age[i] != c_age_max) age[i] <= age[i] + c_age_bits'(1);
         end
         if (do_push) begin
            age[wr_ptr] <= '0;
            wr_ptr      <= wr_ptr + c_ptr_bits'(1);
         end
         if (pop) rd_ptr <= rd_ptr + c_ptr_bits'(1);
         count <= count + (c_ptr_bits + 1)'(do_push) - (c_ptr_bits + 1)'(pop);
      end
   end

endmodule

// File: rtl/mem_server_nport.sv
// N-port word memory with byte-granular writes, a backdoor init port and a
// delayed, in-order response queue per port.
module mem_server_nport
   import mem_server_nport_pkg::*;
#(
   parameter int p_num_ports   = 2,
   parameter int p_opaq_bits   = c_opaq_bits,
   parameter int p_mem_words   = 4096,
   parameter int p_queue_depth = 4,
   parameter int p_resp_delay  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [p_num_ports-1:0]     req_val,
   output logic [p_num_ports-1:0]     req_rdy,
   input  mem_req_t [p_num_ports-1:0] req_msg,
   output logic [p_num_ports-1:0]     resp_val,
   input  logic [p_num_ports-1:0]     resp_rdy,
   output mem_resp_t [p_num_ports-1:0] resp_msg,
   input  logic                       init_en,
   input  logic [31:0]                init_addr,
   input  logic [31:0]                init_data
);

   localparam int c_idx_bits = $clog2(p_mem_words);
   localparam logic [c_opaq_bits-1:0] c_opaq_mask =
      {c_opaq_bits{1'b1}} >> (c_opaq_bits - p_opaq_bits);

   logic [31:0]                mem [p_mem_words];
   logic [p_num_ports-1:0]     full, accept;
   mem_resp_t [p_num_ports-1:0] resp_in;
   logic [c_idx_bits-1:0]      idx     [p_num_ports];
   logic [3:0]                 wr_mask [p_num_ports];
   logic [31:0]                wr_data [p_num_ports];
   logic                       unused_init_bits;

   assign unused_init_bits = ^{init_addr[31:2+c_idx_bits], init_addr[1:0]};
   assign req_rdy = ~full & {p_num_ports{~rst}};

   // NOTE: every output of this block gets a default before any branch, so
   // no path leaves a value held and no latch is inferred.
   always_comb begin
      accept  = '0;
      resp_in = '0;
      for (int p = 0; p < p_num_ports; p++) begin
         idx[p]     = req_msg[p].addr[2 +: c_idx_bits];
         wr_mask[p] = byte_mask(req_msg[p].addr[1:0], req_msg[p].len);
         wr_data[p] = req_msg[p].data << {req_msg[p].addr[1:0], 3'b000};
         accept[p]  = req_val[p] && req_rdy[p];

         resp_in[p].op     = req_msg[p].op;
         resp_in[p].opaque = req_msg[p].opaque & c_opaq_mask;
         resp_in[p].addr   = req_msg[p].addr;
         resp_in[p].len    = req_msg[p].len;
         if (req_msg[p].op == OP_READ)
            resp_in[p].data = (mem[idx[p]] >> {req_msg[p].addr[1:0], 3'b000})
                              & len_mask(req_msg[p].len);
      end
   end

   // Later statements win: higher ports override lower ones, init overrides all.
   always_ff @(posedge clk) begin
      for (int p = 0; p < p_num_ports; p++) begin
         if (accept[p] && req_msg[p].op == OP_WRITE) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_mask[p][b]) mem[idx[p]][8*b +: 8] <= wr_data[p][8*b +: 8];
            end
         end
      end
      if (init_en) mem[init_addr[2 +: c_idx_bits]] <= init_data;
   end

   for (genvar p = 0; p < p_num_ports; p++) begin : g_port
      mem_server_resp_queue #(
         .p_depth (p_queue_depth),
         .p_delay (p_resp_delay)
      ) u_queue (
         .clk      (clk),
         .rst      (rst),
         .push     (accept[p]),
         .push_msg (resp_in[p]),
         .full     (full[p]),
         .pop_rdy  (resp_rdy[p]),
         .head_val (resp_val[p]),
         .head_msg (resp_msg[p])
      );
   end

endmodule

// File: tb/tb_mem_server_nport.sv
// Scoreboard bench for mem_server_nport: a byte-level memory model predicts
// each response, and a monitor compares whatever the DUT presents.
module tb_mem_server_nport;
   import mem_server_nport_pkg::*;

   localparam int NP    = 3;
   localparam int DEPTH = 4;
   localparam int DELAY = 1;
   localparam int WORDS = 4096;

   typedef struct {
      mem_resp_t msg;
      int        acc_cyc;
   } exp_t;

   logic                 clk;
   logic                 rst;
   logic [NP-1:0]        req_val, req_rdy, resp_val, resp_rdy;
   mem_req_t [NP-1:0]    req_msg;
   mem_resp_t [NP-1:0]   resp_msg;
   logic                 init_en;
   logic [31:0]          init_addr, init_data;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   exp_t        sb [NP][$];
   logic [31:0] mdl [WORDS];
   logic [NP-1:0] acc_last;
   logic [31:0] last_pop_data [NP];
   logic [7:0]  last_pop_opq  [NP];
   int          last_pop_cyc  [NP];
   int          pops          [NP];

   mem_server_nport #(
      .p_num_ports   (NP),
      .p_opaq_bits   (8),
      .p_mem_words   (WORDS),
      .p_queue_depth (DEPTH),
      .p_resp_delay  (DELAY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req_msg   (req_msg),
      .resp_val  (resp_val),
      .resp_rdy  (resp_rdy),
      .resp_msg  (resp_msg),
      .init_en   (init_en),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'd0) ? 4 : int'(len);
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) % WORDS);
   endfunction

   function automatic logic [31:0] mdl_read(input logic [31:0] addr, input logic [1:0] len);
      logic [31:0] w, r;
      int off;
      w   = mdl[widx(addr)];
      off = int'(addr[1:0]);
      r   = '0;
      for (int k = 0; k < nbytes(len); k++)
         if (off + k < 4) r[8*k +: 8] = w[8*(off+k) +: 8];
      return r;
   endfunction

   task automatic mdl_write(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
      int off;
      off = int'(addr[1:0]);
      for (int k = 0; k < nbytes(len); k++)
         if (off + k < 4) mdl[widx(addr)][8*(off+k) +: 8] = data[8*k +: 8];
   endtask

   function automatic logic [63:0] hdr(input mem_resp_t m);
      return {21'b0, m.op, m.opaque, m.addr, m.len};
   endfunction

   function automatic mem_req_t mk(input mem_op_e op, input logic [7:0] opq,
                                   input logic [31:0] addr, input logic [1:0] len,
                                   input logic [31:0] data);
      mem_req_t m;
      m.op = op; m.opaque = opq; m.addr = addr; m.len = len; m.data = data;
      return m;
   endfunction

   function automatic logic [31:0] rand_addr();
      return ($urandom & 32'hffff_c000) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
   endfunction

   // ---------------- driver ----------------
   // Called right after a falling edge with inputs already applied.
   task automatic step();
      exp_t e;
      #1;
      acc_last = '0;
      if (rst) begin
         for (int p = 0; p < NP; p++) sb[p].delete();
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (req_val[p] && req_rdy[p]) begin
               acc_last[p]    = 1'b1;
               e.msg.op       = req_msg[p].op;
               e.msg.opaque   = req_msg[p].opaque;
               e.msg.addr     = req_msg[p].addr;
               e.msg.len      = req_msg[p].len;
               e.msg.data     = (req_msg[p].op == OP_READ) ?
                                mdl_read(req_msg[p].addr, req_msg[p].len) : 32'h0;
               e.acc_cyc      = cyc;
               sb[p].push_back(e);
            end
         end
         for (int p = 0; p < NP; p++)
            if (acc_last[p] && req_msg[p].op == OP_WRITE)
               mdl_write(req_msg[p].addr, req_msg[p].len, req_msg[p].data);
      end
      if (init_en) mdl[widx(init_addr)] = init_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      req_val = '0;
      req_msg = '0;
      init_en = 1'b0;
   endtask

   task automatic init_word(input logic [31:0] addr, input logic [31:0] data);
      idle();
      init_en = 1'b1; init_addr = addr; init_data = data;
      step();
      init_en = 1'b0;
   endtask

   task automatic send(input int p, input mem_req_t m);
      idle();
      req_val[p] = 1'b1;
      req_msg[p] = m;
      step();
      check("send_accepted", acc_last[p], 1);
      idle();
   endtask

   task automatic drain(input int budget);
      int left;
      idle();
      for (int i = 0; i < budget; i++) begin
         left = 0;
         for (int p = 0; p < NP; p++) left += sb[p].size();
         if (left == 0) break;
         step();
      end
      left = 0;
      for (int p = 0; p < NP; p++) left += sb[p].size();
      check("drain_empty", left, 0);
      step();
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [NP-1:0] held;
      mem_resp_t     held_msg [NP];
      exp_t          e;
      held = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            check("rst_req_rdy", req_rdy, 0);
            check("rst_resp_val", resp_val, 0);
            check("rst_resp_msg", {63'b0, |resp_msg}, 0);
            held = '0;
         end else begin
            for (int p = 0; p < NP; p++) begin
               if (held[p]) begin
                  check("hold_val", resp_val[p], 1);
                  check("hold_msg", {63'b0, resp_msg[p] != held_msg[p]}, 0);
               end
               if (sb[p].size() == 0) begin
                  check("spurious_resp", resp_val[p], 0);
               end else if (resp_val[p]) begin
                  e = sb[p][0];
                  check("resp_hdr", hdr(resp_msg[p]), hdr(e.msg));
                  check("resp_data", resp_msg[p].data, e.msg.data);
                  check("resp_early", {63'b0, (cyc - e.acc_cyc) >= 1 + DELAY}, 1);
                  if (resp_rdy[p]) begin
                     void'(sb[p].pop_front());
                     last_pop_data[p] = resp_msg[p].data;
                     last_pop_opq[p]  = resp_msg[p].opaque;
                     last_pop_cyc[p]  = cyc;
                     pops[p]++;
                  end
               end
               held[p]     = resp_val[p] && !resp_rdy[p];
               held_msg[p] = resp_msg[p];
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, accepted, p0_pops;
      for (int p = 0; p < NP; p++) begin
         pops[p] = 0; last_pop_cyc[p] = 0; last_pop_data[p] = '0; last_pop_opq[p] = '0;
      end
      rst = 1'b1; resp_rdy = '1; init_addr = '0; init_data = '0;
      idle();
      @(negedge clk);
      step();
      // Backdoor write while in reset must land.
      init_word(32'h40, 32'h0000_0055);
      step();
      rst = 1'b0;
      step();
      check("rdy_after_reset", req_rdy, {NP{1'b1}});

      for (int i = 0; i < 16; i++) init_word(32'(i * 4), $urandom);

      // Single read with exact latency.
      init_word(32'h100, 32'hdead_beef);
      n = cyc;
      send(0, mk(OP_READ, 8'h3, 32'h100, 2'd0, 32'h0));
      for (int i = 0; i < 3; i++) step();
      check("single_read_data", last_pop_data[0], 32'hdead_beef);
      check("single_read_opq", last_pop_opq[0], 8'h3);
      check("single_read_lat", last_pop_cyc[0], n + 2);

      // Byte write into the top lane.
      init_word(32'h200, 32'h1122_3344);
      send(1, mk(OP_WRITE, 8'h5, 32'h203, 2'd1, 32'h0000_00ab));
      send(1, mk(OP_READ, 8'h6, 32'h200, 2'd0, 32'h0));
      drain(20);
      check("byte_write_merge", last_pop_data[1], 32'hab22_3344);

      // Same-cycle collision with a concurrent read.
      idle();
      req_val    = '1;
      req_msg[0] = mk(OP_WRITE, 8'h10, 32'h40, 2'd0, 32'h1);
      req_msg[1] = mk(OP_WRITE, 8'h11, 32'h40, 2'd0, 32'h2);
      req_msg[2] = mk(OP_READ,  8'h12, 32'h40, 2'd0, 32'h0);
      step();
      check("collide_all_acc", acc_last, {NP{1'b1}});
      drain(20);
      check("collide_read_old", last_pop_data[2], 32'h55);
      send(2, mk(OP_READ, 8'h13, 32'h40, 2'd0, 32'h0));
      drain(20);
      check("collide_winner", last_pop_data[2], 32'h2);

      // Address wrap past the top of storage.
      send(0, mk(OP_WRITE, 8'h20, 32'h4000, 2'd0, 32'hcafe_0001));
      send(0, mk(OP_READ, 8'h21, 32'h0, 2'd0, 32'h0));
      drain(20);
      check("wrap_read", last_pop_data[0], 32'hcafe_0001);

      // Backpressure: queue fills at DEPTH entries.
      resp_rdy[0] = 1'b0;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         idle();
         req_val[0] = 1'b1;
         req_msg[0] = mk(OP_READ, 8'(accepted), 32'h100, 2'd0, 32'h0);
         step();
         if (acc_last[0]) accepted++;
      end
      check("bp_accepted", accepted, DEPTH);
      check("bp_rdy_low", req_rdy[0], 0);
      resp_rdy[0] = 1'b1;
      req_val[0]  = 1'b1;
      req_msg[0]  = mk(OP_READ, 8'd4, 32'h100, 2'd0, 32'h0);
      step();
      check("bp_full_pop_rdy", acc_last[0], 0);
      for (int i = 0; i < 10 && !acc_last[0]; i++) step();
      check("bp_fifth_acc", acc_last[0], 1);
      drain(30);
      check("bp_last_opq", last_pop_opq[0], 8'd4);

      // Reset with a read in flight.
      send(0, mk(OP_READ, 8'h9, 32'h100, 2'd0, 32'h0));
      p0_pops = pops[0];
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("rst_no_resp", pops[0] - p0_pops, 0);
      send(0, mk(OP_READ, 8'ha, 32'h100, 2'd0, 32'h0));
      drain(20);
      check("rst_mem_kept", last_pop_data[0], 32'hdead_beef);

      // Randomized traffic with occasional backdoor writes and resets.
      for (int i = 0; i < 400; i++) begin
         idle();
         rst = ($urandom_range(149) == 0);
         for (int p = 0; p < NP; p++) begin
            resp_rdy[p] = ($urandom_range(3) != 0);
            req_val[p]  = 1'($urandom_range(1));
            req_msg[p]  = mk(mem_op_e'($urandom_range(1)), 8'($urandom), rand_addr(),
                             2'($urandom_range(3)), $urandom);
         end
         if ($urandom_range(15) == 0) begin
            init_en = 1'b1; init_addr = rand_addr(); init_data = $urandom;
         end
         step();
      end
      rst = 1'b0;
      resp_rdy = '1;
      drain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_server_nport.md
MEM_SERVER_NPORT -- requirements
Module: mem_server_nport

Interface
REQ-001 SHALL have parameter p_num_ports, default 2: number of independent memory ports.
REQ-002 SHALL have parameter p_opaq_bits, default 8: opaque tag width.
REQ-003 SHALL have parameter p_mem_words, default 4096: 32-bit words of storage; a power of two.
REQ-004 SHALL have parameter p_queue_depth, default 4: response queue entries per port; a power of two, at least 2.
REQ-005 SHALL have parameter p_resp_delay, default 1: extra cycles before a queued response is presented.
REQ-006 SHALL have the following ports, one per line; reset is synchronous and active-high, with one clock.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_val  in  p_num_ports  per-port request valid
- req_rdy  out  p_num_ports  per-port request ready
- req_msg  in  p_num_ports x mem_req_t  op, opaque, addr[31:0], len[1:0], data[31:0]
- resp_val  out  p_num_ports  per-port response valid
- resp_rdy  in  p_num_ports  per-port response ready
- resp_msg  out  p_num_ports x mem_resp_t  op, opaque, addr, len, data
- init_en  in  1  backdoor write strobe
- init_addr  in  32  backdoor byte address
- init_data  in  32  backdoor word

Function
REQ-007 SHALL accept a port request on a cycle when req_val and req_rdy are both high; req_rdy = not rst and that port's queue not full.
REQ-008 SHALL perform the memory access in the accept cycle; word index = addr[2+log2(p_mem_words)-1:2], so out-of-range addresses wrap.
REQ-009 SHALL encode op as 0 = read and 1 = write; len 0 = 4 bytes, 1..3 = that many bytes starting at byte addr[1:0].
REQ-010 SHALL write only the bytes selected for a write; bytes past byte 3 of the word are dropped, with no wrap into the next word.
REQ-011 SHALL return read data right-aligned and zero-extended, and SHALL return data 0 for a write.
REQ-012 SHALL echo op, opaque, addr and len unchanged in the response.
REQ-013 SHALL give a read in cycle T the memory state before any write in cycle T, including writes from other ports.
REQ-014 SHALL resolve same-cycle writes to the same byte as follows: the highest-indexed port wins, and init_en overrides all ports.
REQ-015 SHALL assert resp_val for a request accepted in cycle T no earlier than cycle T+1+p_resp_delay.
REQ-016 SHALL keep an age counter per queue entry, saturating at p_resp_delay; resp_val = queue not empty and head age equals p_resp_delay.
REQ-017 SHALL keep responses in order per port, with no ordering relation across ports.
REQ-018 SHALL pop the head when resp_val and resp_rdy are both high.
REQ-019 SHALL allow push and pop on a full queue in the same cycle; req_rdy is from registered occupancy, so a full queue stays not-ready that cycle even if popping.
REQ-020 SHALL hold resp_msg stable while resp_val is high and resp_rdy is low.
REQ-021 SHALL wrap the read and write pointers modulo p_queue_depth, with a separate count distinguishing full from empty.
REQ-022 SHALL perform init_en writes as a full word in the same cycle, independent of port traffic.

Reset
REQ-023 SHALL drive req_rdy = 0, resp_val = 0 and resp_msg = 0 during rst.
REQ-024 SHALL clear all queue counts, pointers and ages on rst, discarding in-flight responses.
REQ-025 SHALL NOT clear memory contents on rst; init_en SHALL also work during rst.
REQ-026 SHALL ignore requests during rst; with rst asserted mid-transfer, no response for a pre-reset request appears after reset.

Structure
REQ-027 SHALL place mem_req_t, mem_resp_t (parametrised by p_opaq_bits) and the op encodings in a shared package.
REQ-028 SHALL use one sub-module, mem_server_resp_queue, instantiated per port: a FIFO with an age counter per entry.
REQ-029 SHALL keep the storage array and byte-merge logic in the top module.

Verification
REQ-030 Single read: init_en addr 0x100, data 0xDEADBEEF; port 0 read addr 0x100, len 0, opaque 0x3 at T -> resp_val at T+2 with data 0xDEADBEEF, opaque 0x3.
REQ-031 Byte write then read: port 1 write addr 0x203, len 1, data 0xAB, over word 0x11223344 -> read returns 0xAB223344.
REQ-032 Same-cycle collision: port 0 writes 0x1 and port 1 writes 0x2 to 0x40, while a read of 0x40 is accepted in the same cycle -> read returns the old value, and a later read returns 0x2.
REQ-033 Backpressure: resp_rdy held low, 5 requests on port 0 -> exactly 4 accepted and req_rdy low; release -> 4 in-order responses with opaques 0..3, then the 5th accepted.
REQ-034 Wrap: p_mem_words 4096, write to 0x4000 -> a read of 0x0 returns the written data.
REQ-035 Reset mid-flight: accept a read, assert rst in T+1 -> no resp_val after reset, and memory is preserved.
